// File: rtl/throw_power_ctl.sv
// Throw charge meter: debounced button ramps a power value, releases fire a one-cycle enable.
// Define THROW_PWR_PINGPONG_EN for an up/down ramp; default build saturates at PWR_MAX.
module throw_power_ctl #(
  parameter int unsigned DEBOUNCE_CYC = 200000,
  parameter int unsigned TICK_DIV     = 400000,
  parameter int unsigned PWR_MAX      = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       busy,
  output logic       enable,
  output logic [7:0] power,
  output logic       charging,
  output logic [7:0] meter
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int unsigned TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [7:0]      PMAX    = 8'(PWR_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHARGE = 2'd1;
  localparam logic [1:0] ST_FIRE   = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_dly_q;
  logic            rise_c, fall_c;

  logic [1:0]      state_q, state_d;
  logic [TK_W-1:0] tick_q, tick_d;
  logic [7:0]      live_q, live_d;
  logic [7:0]      power_q, power_d;
  logic            enable_q, enable_d;
  logic            charging_q, charging_d;
  logic [7:0]      meter_q, meter_d;
`ifdef THROW_PWR_PINGPONG_EN
  logic            dir_up_q, dir_up_d;
`endif

  // Debounce: count consecutive cycles the synchronised level disagrees with the accepted one
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise_c = btn_db_q & ~btn_db_dly_q;
  assign fall_c = ~btn_db_q & btn_db_dly_q;

  // Next state, ramp and latched power
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    live_d  = live_q;
    power_d = power_q;
`ifdef THROW_PWR_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise_c && !busy) begin
          state_d = ST_CHARGE;
          tick_d  = '0;
          live_d  = '0;
`ifdef THROW_PWR_PINGPONG_EN
          dir_up_d = 1'b1;
`endif
        end
      end
      ST_CHARGE: begin
        // Release takes priority over a coincident tick so the pre-step value is kept
        if (fall_c) begin
          if (live_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            power_d = live_q;
            state_d = ST_FIRE;
          end
        end else if (tick_q == TK_LAST) begin
          tick_d = '0;
`ifdef THROW_PWR_PINGPONG_EN
          if (dir_up_q) begin
            if (live_q >= PMAX) begin
              dir_up_d = 1'b0;
              live_d   = live_q - 8'd1;
            end else begin
              live_d = live_q + 8'd1;
            end
          end else begin
            if (live_q == 8'd0) begin
              dir_up_d = 1'b1;
              live_d   = 8'd1;
            end else begin
              live_d = live_q - 8'd1;
            end
          end
`else
          if (live_q < PMAX) begin
            live_d = live_q + 8'd1;
          end
`endif
        end else begin
          tick_d = tick_q + TK_W'(1);
        end
      end
      ST_FIRE: begin
        state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (!busy && !btn_db_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from next-state so they line up with the state register
  always_comb begin
    enable_d   = (state_d == ST_FIRE);
    charging_d = (state_d == ST_CHARGE);
    meter_d    = charging_d ? live_d : power_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      live_q       <= '0;
      power_q      <= '0;
      enable_q     <= 1'b0;
      charging_q   <= 1'b0;
      meter_q      <= '0;
`ifdef THROW_PWR_PINGPONG_EN
      dir_up_q     <= 1'b1;
`endif
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      live_q       <= live_d;
      power_q      <= power_d;
      enable_q     <= enable_d;
      charging_q   <= charging_d;
      meter_q      <= meter_d;
`ifdef THROW_PWR_PINGPONG_EN
      dir_up_q     <= dir_up_d;
`endif
    end
  end

  assign enable   = enable_q;
  assign power    = power_q;
  assign charging = charging_q;
  assign meter    = meter_q;

endmodule
